// File: rtl/trace_chk_pkg.sv
// Shared types and constants for the trace line checker: FSM states,
// the ASCII punctuation of a trace record and the error_code bit map.
package trace_chk_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TIME,
        ST_AT,
        ST_PC,
        ST_COLON_SP,
        ST_GRF,
        ST_GRF_SP,
        ST_ADDR,
        ST_ADDR_SP,
        ST_LT,
        ST_EQ,
        ST_DATA_SP,
        ST_DATA,
        ST_ACC_REG,
        ST_ACC_MEM
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SP     = 8'h20;

    localparam int ERR_PC_RANGE = 0;
    localparam int ERR_PC_ALIGN = 1;
    localparam int ERR_GRF      = 2;
    localparam int ERR_ADDR     = 3;

    localparam int GRF_W = 14;

    // Decimal accumulate step g*10 + d, pinned at all-ones instead of wrapping.
    function automatic logic [GRF_W-1:0] grf_step(input logic [GRF_W-1:0] g,
                                                  input logic [3:0]       d);
        logic [GRF_W+3:0] sum;
        sum = {4'b0000, g} * 18'd10 + {14'b0, d};
        if (sum > {4'b0000, {GRF_W{1'b1}}}) begin
            return {GRF_W{1'b1}};
        end
        return sum[GRF_W-1:0];
    endfunction

endpackage

// File: rtl/trace_char_class.sv
// Combinational character classifier: decimal digit, lowercase hex digit,
// space, and the 4-bit value of a hex digit.
module trace_char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic       is_sp,
    output logic [3:0] nibble
);
    import trace_chk_pkg::*;

    logic is_af;

    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_af  = (char >= 8'h61) && (char <= 8'h66);
        is_hex = is_dec || is_af;
        is_sp  = (char == CH_SP);
        // '0'-'9' carry their value in the low nibble; 'a'-'f' sit at 1..6, so add 9.
        if (is_af) begin
            nibble = char[3:0] + 4'd9;
        end else if (is_dec) begin
            nibble = char[3:0];
        end else begin
            nibble = 4'd0;
        end
    end

endmodule

// File: rtl/trace_line_checker.sv
// Streaming recogniser for "^T@PC: $G <= D#" and "^T@PC: *A <= D#" trace lines
// with range/alignment flags and a running count of accepted records.
module trace_line_checker
    import trace_chk_pkg::*;
#(
    parameter int          TIME_DIG = 4,
    parameter int          GRF_DIG  = 4,
    parameter int          HEX_DIG  = 8,
    parameter int          REG_MAX  = 31,
    parameter logic [31:0] PC_MIN   = 32'h3000,
    parameter logic [31:0] PC_MAX   = 32'h4ffc,
    parameter logic [31:0] ADDR_MAX = 32'h2ffc,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    // char_valid qualifies char. There is no ready: a char is consumed on every
    // rising clk with char_valid = 1, and nothing changes on a cycle with it 0.
    input  logic             char_valid,
    input  logic [7:0]       char,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [CNT_W-1:0] rec_cnt,
    output state_t           dbg_state
);

    localparam int DIG_MAX = (TIME_DIG > GRF_DIG)
                           ? ((TIME_DIG > HEX_DIG) ? TIME_DIG : HEX_DIG)
                           : ((GRF_DIG > HEX_DIG) ? GRF_DIG : HEX_DIG);
    localparam int DW = $clog2(DIG_MAX + 1);

    localparam logic [DW-1:0]    ZERO     = '0;
    localparam logic [DW-1:0]    ONE      = DW'(1);
    localparam logic [DW-1:0]    TIME_LIM = DW'(TIME_DIG);
    localparam logic [DW-1:0]    GRF_LIM  = DW'(GRF_DIG);
    localparam logic [DW-1:0]    HEX_LIM  = DW'(HEX_DIG);
    localparam logic [GRF_W-1:0] REG_LIM  = GRF_W'(REG_MAX);

    state_t           state, state_n;
    logic [DW-1:0]    cnt, cnt_n;
    logic             mem_path, mem_path_n;
    logic [31:0]      pc_acc, pc_acc_n;
    logic [GRF_W-1:0] grf_acc, grf_acc_n;
    logic [31:0]      addr_acc, addr_acc_n;
    logic [1:0]       format_type_n;
    logic [3:0]       error_code_n;
    logic [CNT_W-1:0] rec_cnt_n;
    logic [3:0]       err_flags;

    logic       is_dec, is_hex, is_sp;
    logic [3:0] nibble;

    trace_char_class u_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .is_sp  (is_sp),
        .nibble (nibble)
    );

    assign dbg_state = state;

    // Flags are only sampled on the '#' edge, when the accumulators are final.
    always_comb begin
        err_flags               = '0;
        err_flags[ERR_PC_RANGE] = (pc_acc < PC_MIN) || (pc_acc > PC_MAX);
        err_flags[ERR_PC_ALIGN] = (pc_acc[1:0] != 2'b00);
        err_flags[ERR_GRF]      = !mem_path && (grf_acc > REG_LIM);
        err_flags[ERR_ADDR]     = mem_path &&
                                  ((addr_acc > ADDR_MAX) || (addr_acc[1:0] != 2'b00));
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        mem_path_n    = mem_path;
        pc_acc_n      = pc_acc;
        grf_acc_n     = grf_acc;
        addr_acc_n    = addr_acc;
        format_type_n = format_type;
        error_code_n  = error_code;
        rec_cnt_n     = rec_cnt;

        if (char_valid) begin
            format_type_n = 2'd0;
            error_code_n  = 4'd0;
            if (char == CH_CARET) begin
                state_n    = ST_TIME;
                cnt_n      = ZERO;
                pc_acc_n   = '0;
                grf_acc_n  = '0;
                addr_acc_n = '0;
            end else begin
                state_n = ST_IDLE;
                unique case (state)
                    ST_TIME: begin
                        if (is_dec && cnt != TIME_LIM) begin
                            state_n = ST_TIME;
                            cnt_n   = cnt + ONE;
                        end else if (char == CH_AT && cnt != ZERO) begin
                            state_n = ST_AT;
                        end
                    end
                    ST_AT: begin
                        if (is_hex) begin
                            state_n  = ST_PC;
                            cnt_n    = ONE;
                            pc_acc_n = {pc_acc[27:0], nibble};
                        end
                    end
                    ST_PC: begin
                        if (is_hex && cnt != HEX_LIM) begin
                            state_n  = ST_PC;
                            cnt_n    = cnt + ONE;
                            pc_acc_n = {pc_acc[27:0], nibble};
                        end else if (char == CH_COLON && cnt == HEX_LIM) begin
                            state_n = ST_COLON_SP;
                        end
                    end
                    ST_COLON_SP: begin
                        if (is_sp) begin
                            state_n = ST_COLON_SP;
                        end else if (char == CH_DOLLAR) begin
                            state_n    = ST_GRF;
                            cnt_n      = ZERO;
                            mem_path_n = 1'b0;
                        end else if (char == CH_STAR) begin
                            state_n    = ST_ADDR;
                            cnt_n      = ZERO;
                            mem_path_n = 1'b1;
                        end
                    end
                    ST_GRF: begin
                        // Spaces between '$' and the first digit are tolerated.
                        if (is_dec && cnt != GRF_LIM) begin
                            state_n   = ST_GRF;
                            cnt_n     = cnt + ONE;
                            grf_acc_n = grf_step(grf_acc, nibble);
                        end else if (is_sp && cnt == ZERO) begin
                            state_n = ST_GRF;
                        end else if (is_sp) begin
                            state_n = ST_GRF_SP;
                        end else if (char == CH_LT && cnt != ZERO) begin
                            state_n = ST_LT;
                        end
                    end
                    ST_ADDR: begin
                        if (is_hex && cnt != HEX_LIM) begin
                            state_n    = ST_ADDR;
                            cnt_n      = cnt + ONE;
                            addr_acc_n = {addr_acc[27:0], nibble};
                        end else if (is_sp && cnt == HEX_LIM) begin
                            state_n = ST_ADDR_SP;
                        end else if (char == CH_LT && cnt == HEX_LIM) begin
                            state_n = ST_LT;
                        end
                    end
                    ST_GRF_SP, ST_ADDR_SP: begin
                        if (is_sp) begin
                            state_n = state;
                        end else if (char == CH_LT) begin
                            state_n = ST_LT;
                        end
                    end
                    ST_LT: begin
                        if (char == CH_EQ) begin
                            state_n = ST_EQ;
                        end
                    end
                    ST_EQ, ST_DATA_SP: begin
                        if (is_sp) begin
                            state_n = ST_DATA_SP;
                        end else if (is_hex) begin
                            state_n = ST_DATA;
                            cnt_n   = ONE;
                        end
                    end
                    ST_DATA: begin
                        if (is_hex && cnt != HEX_LIM) begin
                            state_n = ST_DATA;
                            cnt_n   = cnt + ONE;
                        end else if (char == CH_HASH && cnt == HEX_LIM) begin
                            state_n       = mem_path ? ST_ACC_MEM : ST_ACC_REG;
                            format_type_n = mem_path ? 2'd2 : 2'd1;
                            error_code_n  = err_flags;
                            rec_cnt_n     = rec_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_n = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mem_path    <= 1'b0;
            pc_acc      <= '0;
            grf_acc     <= '0;
            addr_acc    <= '0;
            format_type <= '0;
            error_code  <= '0;
            rec_cnt     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_path    <= mem_path_n;
            pc_acc      <= pc_acc_n;
            grf_acc     <= grf_acc_n;
            addr_acc    <= addr_acc_n;
            format_type <= format_type_n;
            error_code  <= error_code_n;
            rec_cnt     <= rec_cnt_n;
        end
    end

endmodule

// File: tb/tb_trace_line_checker.sv
// Bench for trace_line_checker: table of spec-derived lines, stall/reset
// sequences, then random lines checked against a string-parsing reference.
module tb_trace_line_checker;
    import trace_chk_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        char_valid;
    logic [7:0]  char;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [15:0] rec_cnt;
    state_t      dbg_state;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_active;
    string       m_buf;
    logic [1:0]  m_ft;
    logic [3:0]  m_err;
    logic [15:0] m_cnt;
    logic [5:0]  exp_q[$];

    typedef struct {
        string      line;
        logic [1:0] ft;
        logic [3:0] err;
        int         inc;
    } vec_t;
    vec_t tbl[$];

    localparam string CASE1 = "^10@00003010: $ 1 <= 0000000a#";

    always #5 clk = ~clk;

    trace_line_checker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .char_valid  (char_valid),
        .char        (char),
        .format_type (format_type),
        .error_code  (error_code),
        .rec_cnt     (rec_cnt),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_dig(input logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_hx(input logic [7:0] c);
        return is_dig(c) || (c >= "a" && c <= "f");
    endfunction

    function automatic logic [63:0] hval(input logic [7:0] c);
        return is_dig(c) ? 64'(c - 8'd48) : 64'(c - 8'd87);
    endfunction

    // Parses the text between '^' and '#' against the record grammar.
    function automatic bit parse_line(input string s, output logic [1:0] ft,
                                      output logic [3:0] err);
        int i, n;
        logic [63:0] pc, a, g;
        bit mem;
        ft = 0; err = 0; i = 0; n = 0; pc = 0; a = 0; g = 0; mem = 0;
        while (i < s.len() && is_dig(s[i])) begin i++; n++; end
        if (n < 1 || n > 4 || i >= s.len() || s[i] != "@") return 0;
        i++; n = 0;
        while (i < s.len() && is_hx(s[i])) begin pc = pc * 16 + hval(s[i]); i++; n++; end
        if (n != 8 || i >= s.len() || s[i] != ":") return 0;
        i++;
        while (i < s.len() && s[i] == " ") i++;
        if (i >= s.len()) return 0;
        if (s[i] == "$") begin
            i++;
            while (i < s.len() && s[i] == " ") i++;
            n = 0;
            while (i < s.len() && is_dig(s[i])) begin g = g * 10 + hval(s[i]); i++; n++; end
            if (n < 1 || n > 4) return 0;
        end else if (s[i] == "*") begin
            mem = 1; i++; n = 0;
            while (i < s.len() && is_hx(s[i])) begin a = a * 16 + hval(s[i]); i++; n++; end
            if (n != 8) return 0;
        end else begin
            return 0;
        end
        while (i < s.len() && s[i] == " ") i++;
        if (i + 1 >= s.len() || s[i] != "<" || s[i+1] != "=") return 0;
        i += 2;
        while (i < s.len() && s[i] == " ") i++;
        n = 0;
        while (i < s.len() && is_hx(s[i])) begin i++; n++; end
        if (n != 8 || i != s.len()) return 0;
        ft     = mem ? 2'd2 : 2'd1;
        err[0] = pc < 64'h3000 || pc > 64'h4ffc;
        err[1] = (pc % 4) != 0;
        err[2] = !mem && g > 31;
        err[3] = mem && (a > 64'h2ffc || (a % 4) != 0);
        return 1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_buf = ""; m_ft = 0; m_err = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [7:0] c);
        logic [1:0] ft;
        logic [3:0] err;
        string t;
        m_ft = 0; m_err = 0;
        if (c == "^") begin
            m_active = 1; m_buf = "";
        end else if (m_active) begin
            if (c == "#") begin
                m_active = 0;
                if (parse_line(m_buf, ft, err)) begin
                    m_ft = ft; m_err = err; m_cnt++;
                    exp_q.push_back({ft, err});
                end
            end else begin
                t = " ";
                t.putc(0, c);
                m_buf = {m_buf, t};
            end
        end
    endtask

    task automatic check_cycle(input bit v);
        logic [5:0] e;
        chk("format_type", 32'(format_type), 32'(m_ft));
        chk("error_code", 32'(error_code), 32'(m_err));
        chk("rec_cnt", 32'(rec_cnt), 32'(m_cnt));
        if (v && format_type != 2'd0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_record", 32'(format_type), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_record", 32'({format_type, error_code}), 32'(e));
            end
        end
    endtask

    task automatic send_char(input logic [7:0] c, input bit v);
        @(negedge clk);
        char       = c;
        char_valid = v;
        @(posedge clk);
        #1;
        if (v) model_step(c);
        check_cycle(v);
    endtask

    task automatic send_line(input string s, input int stall_pct);
        for (int i = 0; i < s.len(); i++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 99) < stall_pct)
                    send_char(8'($urandom_range(0, 255)), 1'b0);
            end
            send_char(s[i], 1'b1);
        end
    endtask

    function automatic string gen_line();
        string s, junk, t;
        int idx;
        logic [31:0] pc, a;
        s = "^";
        repeat ($urandom_range(1, 5)) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
        pc = $urandom_range(0, 1) ? 32'h3000 + 32'($urandom_range(0, 2047)) * 4 : $urandom;
        s = {s, "@", $sformatf("%08x", pc), ":"};
        repeat ($urandom_range(0, 2)) s = {s, " "};
        if ($urandom_range(0, 1) == 1) begin
            s = {s, "$"};
            if ($urandom_range(0, 3) == 0) s = {s, " "};
            if ($urandom_range(0, 7) == 0)
                s = {s, $sformatf("%0d", $urandom_range(1000, 99999))};
            else
                s = {s, $sformatf("%0d", $urandom_range(0, 40))};
        end else begin
            a = $urandom_range(0, 1) ? 32'($urandom_range(0, 3071)) * 4 : $urandom;
            s = {s, "*", $sformatf("%08x", a)};
        end
        repeat ($urandom_range(0, 2)) s = {s, " "};
        s = {s, "<="};
        repeat ($urandom_range(0, 2)) s = {s, " "};
        s = {s, $sformatf("%08x", $urandom), "#"};
        if ($urandom_range(0, 5) == 0) begin
            junk = "0A^x< #9f*:$@";
            t = junk;
            idx = $urandom_range(1, s.len() - 1);
            s.putc(idx, t[$urandom_range(0, t.len() - 1)]);
        end
        return s;
    endfunction

    initial begin
        logic [15:0] tb_cnt;
        tbl.push_back('{"^10@00003010: $ 1 <= 0000000a#", 2'd1, 4'h0, 1});
        tbl.push_back('{"^5@00003000:*00000010 <=  12345678#", 2'd2, 4'h0, 1});
        tbl.push_back('{"^12345@00003000:*00000010 <= 12345678#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^1@00005002: $32 <= 00000000#", 2'd1, 4'h7, 1});
        tbl.push_back('{"^1@00003000:*00003001 <= 00000000#", 2'd2, 4'h8, 1});
        tbl.push_back('{"^1@0000300^2@00003004: $0 <= 00000000#", 2'd1, 4'h0, 1});
        tbl.push_back('{"^1@00003000:*00002ffc<=ffffffff#", 2'd2, 4'h0, 1});
        tbl.push_back('{"^9999@00004ffc: $31 <= 00000000#", 2'd1, 4'h0, 1});
        tbl.push_back('{"^1@00002ffc: $0 <= 00000000#", 2'd1, 4'h1, 1});
        tbl.push_back('{"^1@00004ffd: $9999 <= 00000000#", 2'd1, 4'h7, 1});
        tbl.push_back('{"^1@0000300A: $1 <= 00000000#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^1@00003000: $1 < = 00000000#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^1@000030000: $1 <= 00000000#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^1@00003000: $1 <= 0000000#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^1@00003000: $12345 <= 00000000#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^@00003000: $1 <= 00000000#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^1@00003000: $ <= 00000000#", 2'd0, 4'h0, 0});
        tbl.push_back('{"^1@00003000:  *00000000   <=00000000#", 2'd2, 4'h0, 1});

        // clock/reset
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char       = 8'h00;
        model_reset();
        #1;
        chk("reset_ft", 32'(format_type), 32'd0);
        chk("reset_err", 32'(error_code), 32'd0);
        chk("reset_cnt", 32'(rec_cnt), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // table vectors
        tb_cnt = 16'd0;
        for (int k = 0; k < tbl.size(); k++) begin
            send_line(tbl[k].line, 0);
            tb_cnt = tb_cnt + 16'(tbl[k].inc);
            chk($sformatf("tbl%0d_ft", k), 32'(format_type), 32'(tbl[k].ft));
            chk($sformatf("tbl%0d_err", k), 32'(error_code), 32'(tbl[k].err));
            chk($sformatf("tbl%0d_cnt", k), 32'(rec_cnt), 32'(tb_cnt));
        end

        // stalled delivery of case 1, then hold in ACC_REG while stalled
        send_line(CASE1, 50);
        tb_cnt = tb_cnt + 16'd1;
        chk("stall_ft", 32'(format_type), 32'd1);
        chk("stall_cnt", 32'(rec_cnt), 32'(tb_cnt));
        for (int k = 0; k < 4; k++) begin
            send_char(8'($urandom_range(0, 255)), 1'b0);
            chk("hold_ft", 32'(format_type), 32'd1);
            chk("hold_err", 32'(error_code), 32'd0);
        end
        send_char(8'h0a, 1'b1);
        chk("exit_acc_ft", 32'(format_type), 32'd0);

        // back-to-back: '^' in ACC clears outputs on that edge
        send_line(CASE1, 0);
        send_char("^", 1'b1);
        chk("b2b_ft", 32'(format_type), 32'd0);

        // reset mid-PC
        send_line("^10@0000", 0);
        @(negedge clk);
        reset_n    = 1'b0;
        char_valid = 1'b1;
        char       = "3";
        #2;
        model_reset();
        chk("midreset_ft", 32'(format_type), 32'd0);
        chk("midreset_cnt", 32'(rec_cnt), 32'd0);
        chk("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        chk("midreset_hold_cnt", 32'(rec_cnt), 32'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        char_valid = 1'b0;
        send_line(CASE1, 0);
        chk("postreset_ft", 32'(format_type), 32'd1);
        chk("postreset_err", 32'(error_code), 32'd0);
        chk("postreset_cnt", 32'(rec_cnt), 32'd1);

        // random lines against the reference model
        for (int n = 0; n < 150; n++) begin
            send_line(gen_line(), 25);
            if ($urandom_range(0, 3) == 0) send_char(8'h0a, 1'b1);
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
